// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive constants, state encoding and frame-length helper
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int FRAME_START_BITS = 1;
  localparam int FRAME_STOP_BITS  = 1;

  function automatic int frame_bits(input int data_width, input logic parity_en);
    return FRAME_START_BITS + data_width + (parity_en ? 1 : 0) + FRAME_STOP_BITS;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame configuration and received-word outputs of uart_rx
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PARITY_ENABLE;
  logic                  PARITY_TYPE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PARITY_ERROR;
  logic                  STOP_ERROR;

  modport master (
    output RX_IN, PARITY_ENABLE, PARITY_TYPE,
    input  P_DATA, DATA_VALID, PARITY_ERROR, STOP_ERROR
  );

  modport slave (
    input  RX_IN, PARITY_ENABLE, PARITY_TYPE,
    output P_DATA, DATA_VALID, PARITY_ERROR, STOP_ERROR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter and mid-bit 3-sample majority voter
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic active_i,
  input  logic rx_i,
  output logic bit_o,
  output logic bit_done_o
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] CNT_POST = CW'(PRESCALE / 2 + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    smp_q, smp_d;
  logic          bit_q, bit_d;
  logic          vote;

  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_i) | (smp_q[1] & rx_i);

  always_comb begin
    cnt_d = cnt_q;
    smp_d = smp_q;
    bit_d = bit_q;
    // The start-detect cycle is count 0, so the first counted cycle is 1.
    if (start_i) begin
      cnt_d = CW'(1);
    end else if (active_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
    if (active_i) begin
      if (cnt_q == CNT_PRE)  smp_d[0] = rx_i;
      if (cnt_q == CNT_MID)  smp_d[1] = rx_i;
      if (cnt_q == CNT_POST) bit_d    = vote;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      smp_q <= '0;
      bit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      smp_q <= smp_d;
      bit_q <= bit_d;
    end
  end

  // With PRESCALE = 4 the vote lands on the last count, so bypass the register.
  assign bit_o      = (cnt_q == CNT_POST) ? vote : bit_q;
  assign bit_done_o = active_i && (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver; UART_RX_INPUT_SYNC_EN adds a 2-flop RX_IN synchronizer
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_rx_if.slave   bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  pen_q, pen_d, ptype_q, ptype_d;
  logic                  perr_pend_q, perr_pend_d;
  logic                  valid_q, valid_d, perr_q, perr_d, serr_q, serr_d;
  logic                  rx_s, start_det, active, bit_v, bit_done, exp_par;

`ifdef UART_RX_INPUT_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], bus.RX_IN};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = bus.RX_IN;
`endif

  assign start_det = (state_q == RX_IDLE) && !rx_s;
  assign active    = (state_q != RX_IDLE);
  assign exp_par   = (ptype_q == PARITY_EVEN) ? ^shift_q : ~^shift_q;

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk_i      (CLK),
    .rst_i      (RST),
    .start_i    (start_det),
    .active_i   (active),
    .rx_i       (rx_s),
    .bit_o      (bit_v),
    .bit_done_o (bit_done)
  );

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    pdata_d     = pdata_q;
    pen_d       = pen_q;
    ptype_d     = ptype_q;
    perr_pend_d = perr_pend_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    case (state_q)
      RX_IDLE: if (!rx_s) begin
        state_d     = RX_START;
        pen_d       = bus.PARITY_ENABLE;
        ptype_d     = bus.PARITY_TYPE;
        perr_pend_d = 1'b0;
        bcnt_d      = '0;
      end
      RX_START: if (bit_done) state_d = bit_v ? RX_IDLE : RX_DATA;
      RX_DATA: if (bit_done) begin
        shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          state_d = pen_q ? RX_PARITY : RX_STOP;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      RX_PARITY: if (bit_done) begin
        perr_pend_d = (bit_v != exp_par);
        state_d     = RX_STOP;
      end
      RX_STOP: if (bit_done) begin
        state_d = RX_IDLE;
        serr_d  = !bit_v;
        perr_d  = perr_pend_q;
        if (bit_v && !perr_pend_q) begin
          valid_d = 1'b1;
          pdata_d = shift_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RX_IDLE;
      bcnt_q      <= '0;
      shift_q     <= '0;
      pdata_q     <= '0;
      pen_q       <= 1'b0;
      ptype_q     <= 1'b0;
      perr_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      pdata_q     <= pdata_d;
      pen_q       <= pen_d;
      ptype_q     <= ptype_d;
      perr_pend_q <= perr_pend_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  assign bus.P_DATA       = pdata_q;
  assign bus.DATA_VALID   = valid_q;
  assign bus.PARITY_ERROR = perr_q;
  assign bus.STOP_ERROR   = serr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks of uart_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int DW = 8;
  localparam int P  = 8;
`ifdef UART_RX_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();
  uart_rx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Per-cycle line/config waveform plus expected pulses keyed by cycle: {valid, parity_err, stop_err}.
  logic          wave_rx[$];
  logic          wave_pen[$];
  logic          wave_pty[$];
  logic [2:0]    ev_kind[int];
  logic [DW-1:0] ev_data[int];
  logic [DW-1:0] exp_pdata = '0;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      wave_rx.push_back(lvl);
      wave_pen.push_back(1'($urandom));
      wave_pty.push_back(1'($urandom));
    end
  endfunction

  function automatic void add_idle(input int n);
    push_level(1'b1, n);
  endfunction

  function automatic void add_glitch(input int len);
    push_level(1'b0, len);
    push_level(1'b1, P - len);
  endfunction

  function automatic void add_frame(input logic [DW-1:0] d, input logic pen, input logic pty,
                                    input logic bad_par, input logic stop);
    int s;
    int n;
    s = wave_rx.size();
    n = DW + 2 + (pen ? 1 : 0);
    push_level(1'b0, P);
    for (int i = 0; i < DW; i++) push_level(d[i], P);
    if (pen) push_level((^d) ^ pty ^ bad_par, P);
    push_level(stop, P);
    wave_pen[s + LAT] = pen;
    wave_pty[s + LAT] = pty;
    ev_kind[s + n * P] = {stop && !(pen && bad_par), pen && bad_par, !stop};
    ev_data[s + n * P] = d;
  endfunction

  task automatic play(input int rst_at);
    int         k;
    logic [2:0] ek;
    add_idle(LAT + 4);
    for (int c = 0; c < wave_rx.size(); c++) begin
      @(posedge CLK);
      #1;
      RST               = (c == rst_at);
      bus.RX_IN         = wave_rx[c];
      bus.PARITY_ENABLE = wave_pen[c];
      bus.PARITY_TYPE   = wave_pty[c];
      @(negedge CLK);
      k  = c - LAT;
      ek = 3'b000;
      if (ev_kind.exists(k)) ek = ev_kind[k];
      if (rst_at >= 0 && c == rst_at + 1) exp_pdata = '0;
      if (ek[2]) exp_pdata = ev_data[k];
      chk("DATA_VALID",   c, 32'(bus.DATA_VALID),   32'(ek[2]));
      chk("PARITY_ERROR", c, 32'(bus.PARITY_ERROR), 32'(ek[1]));
      chk("STOP_ERROR",   c, 32'(bus.STOP_ERROR),   32'(ek[0]));
      chk("P_DATA",       c, 32'(bus.P_DATA),       32'(exp_pdata));
    end
    RST = 1'b0;
    wave_rx.delete();
    wave_pen.delete();
    wave_pty.delete();
    ev_kind.delete();
    ev_data.delete();
  endtask

  initial begin
    int s;
    bus.RX_IN         = 1'b1;
    bus.PARITY_ENABLE = 1'b0;
    bus.PARITY_TYPE   = 1'b0;
    RST               = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset DATA_VALID",   0, 32'(bus.DATA_VALID),   32'd0);
    chk("reset PARITY_ERROR", 0, 32'(bus.PARITY_ERROR), 32'd0);
    chk("reset STOP_ERROR",   0, 32'(bus.STOP_ERROR),   32'd0);
    chk("reset P_DATA",       0, 32'(bus.P_DATA),       32'd0);

    // Even parity, good frame: valid at cycle 88.
    add_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    play(-10);
    // Odd parity expects 1, line sends 0: parity error at 88, P_DATA held.
    add_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    play(-10);
    // No parity, stop bit 0: stop error at 80.
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(P);
    play(-10);
    // Two-cycle low glitch, then 200 quiet cycles.
    push_level(1'b0, 2);
    add_idle(200);
    play(-10);
    // Back-to-back frames: valid at 80 and 160.
    add_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    play(-10);
    // Good frame, then a frame aborted by reset in its cycle 40, then a clean 0x55.
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(5);
    s = wave_rx.size();
    add_frame(8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
    ev_kind.delete(s + 11 * P);
    ev_data.delete(s + 11 * P);
    while (wave_rx.size() > s + 41) begin
      void'(wave_rx.pop_back());
      void'(wave_pen.pop_back());
      void'(wave_pty.pop_back());
    end
    add_idle(6);
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    play(s + 40);

    // Randomized mix of frames, parity/stop faults, glitches and gaps.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        add_glitch(int'($urandom_range(1, P / 2)));
      end else begin
        add_frame(DW'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0);
      end
      add_idle(int'($urandom_range(0, 2)));
    end
    play(-10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
